reg_file_wb: RTL and testbench

Write-back stage and register file for the 16-bit core, with a built-in five-phase instruction sequencer. It consumes `write_add` and `writeOrder` from the write-address decoder and the result word from the ALU/memory path, and commits the result to one of eight 16-bit registers in phase 5. The decoder and ALU read their operands through two asynchronous read ports. The one-hot phase vector it drives is the phase reference for the rest of the datapath.

---
 rtl/reg_file_wb.sv | 137 +++++++++++++
 tb/tb_reg_file_wb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
//   Write-back stage and 8 x DATA_W register file for the 16-bit core, with a
//   five-phase instruction sequencer (P1 fetch .. P5 write-back). The result
//   word is committed to the register file only at the edge that closes P5.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   exec         start/resume request (level), honoured only in IDLE/HALTED
//   halt_req     halt request, sampled only in P5
//   write_add    destination register index
//   writeOrder   write enable, effective only in P5
//   wb_data      result word to commit
//   rd_addr_a/b  read port indices
//   rd_data_a/b  combinational read data (no write-through bypass)
//   phase        registered one-hot phase, 0 when not running
//   running      registered, sequencer in P1..P5
//   halted       registered, sequencer stopped by halt_req
//   instr_count  number of completed P5 phases, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module reg_file_wb #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              exec,
  input  logic              halt_req,
  input  logic [2:0]        write_add,
  input  logic              writeOrder,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        rd_addr_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [4:0]        phase,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_P1     = 3'd1,
    S_P2     = 3'd2,
    S_P3     = 3'd3,
    S_P4     = 3'd4,
    S_P5     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0]        phase_reg, phase_next;
  logic              running_reg, running_next;
  logic              halted_reg, halted_next;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] regs_reg [8];
  logic              commit;
  logic [7:0]        we;

  // A commit happens only on the edge that closes P5.
  assign commit = (state_reg == S_P5) && writeOrder;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_we
      assign we[gi] = commit && (write_add == 3'(gi));
    end
  endgenerate

  // Next-state logic; the status outputs are decoded from the next state so
  // that they can be registered alongside the state itself.
  always_comb begin
    state_next   = state_reg;
    phase_next   = 5'b00000;
    running_next = 1'b0;
    halted_next  = 1'b0;

    case (state_reg)
      S_IDLE, S_HALTED: if (exec) state_next = S_P1;
      S_P1:             state_next = S_P2;
      S_P2:             state_next = S_P3;
      S_P3:             state_next = S_P4;
      S_P4:             state_next = S_P5;
      S_P5:             state_next = halt_req ? S_HALTED : S_P1;
      default:          state_next = S_IDLE;
    endcase

    case (state_next)
      S_P1:    phase_next = 5'b00001;
      S_P2:    phase_next = 5'b00010;
      S_P3:    phase_next = 5'b00100;
      S_P4:    phase_next = 5'b01000;
      S_P5:    phase_next = 5'b10000;
      default: phase_next = 5'b00000;
    endcase

    running_next = (phase_next != 5'b00000);
    halted_next  = (state_next == S_HALTED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      phase_reg   <= 5'b00000;
      running_reg <= 1'b0;
      halted_reg  <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      running_reg <= running_next;
      halted_reg  <= halted_next;
      if (state_reg == S_P5) count_reg <= count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (we[i]) regs_reg[i] <= wb_data;
      end
    end
  end

  // Reads come straight from storage: a commit shows up one cycle later.
  assign rd_data_a   = regs_reg[rd_addr_a];
  assign rd_data_b   = regs_reg[rd_addr_b];
  assign phase       = phase_reg;
  assign running     = running_reg;
  assign halted      = halted_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_reg_file_wb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wb
//   Self-checking bench for reg_file_wb. Two instances share all stimulus: one
//   with the default counter width and one with CNT_W=4 for the wrap check.
//   A behavioural model (phase number, register array, instruction total)
//   predicts every observable output.
// -----------------------------------------------------------------------------
module tb_reg_file_wb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        exec;
  logic        halt_req;
  logic [2:0]  write_add;
  logic        writeOrder;
  logic [15:0] wb_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [4:0]  phase;
  logic        running, halted;
  logic [15:0] instr_count;
  logic [15:0] rd_data_a4, rd_data_b4;
  logic [4:0]  phase4;
  logic        running4, halted4;
  logic [3:0]  instr_count4;

  always #5 clock = ~clock;

  reg_file_wb #(.DATA_W(16), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .exec(exec), .halt_req(halt_req),
    .write_add(write_add), .writeOrder(writeOrder), .wb_data(wb_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .phase(phase), .running(running), .halted(halted),
    .instr_count(instr_count)
  );

  reg_file_wb #(.DATA_W(16), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .exec(exec), .halt_req(halt_req),
    .write_add(write_add), .writeOrder(writeOrder), .wb_data(wb_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a4), .rd_data_b(rd_data_b4),
    .phase(phase4), .running(running4), .halted(halted4),
    .instr_count(instr_count4)
  );

  int tests;
  int fails;

  // Reference model: m_phase 0 = idle, 1..5 = P1..P5, 6 = halted.
  logic [15:0] m_regs [8];
  int          m_phase;
  int unsigned m_count;
  int unsigned cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_phase = 0;
    m_count = 0;
  endtask

  // Applies the effect of one rising edge, using the inputs present before it.
  task automatic model_edge();
    if (m_phase == 5) begin
      if (writeOrder) m_regs[write_add] = wb_data;
      m_count = m_count + 1;
      m_phase = halt_req ? 6 : 1;
    end else if (m_phase >= 1 && m_phase <= 4) begin
      m_phase = m_phase + 1;
    end else if (exec) begin
      m_phase = 1;
    end
  endtask

  function automatic logic [31:0] exp_phase();
    if (m_phase >= 1 && m_phase <= 5) return 32'd1 << (m_phase - 1);
    return 32'd0;
  endfunction

  task automatic check_all();
    rd_addr_a = 3'($urandom_range(0, 7));
    rd_addr_b = 3'($urandom_range(0, 7));
    #1;
    check("phase",    32'(phase),        exp_phase());
    check("running",  32'(running),      32'((m_phase >= 1 && m_phase <= 5) ? 1 : 0));
    check("halted",   32'(halted),       32'((m_phase == 6) ? 1 : 0));
    check("count",    32'(instr_count),  m_count & 32'hFFFF);
    check("count4",   32'(instr_count4), m_count & 32'hF);
    check("phase4",   32'(phase4),       exp_phase());
    check("rd_a",     32'(rd_data_a),    32'(m_regs[rd_addr_a]));
    check("rd_b",     32'(rd_data_b),    32'(m_regs[rd_addr_b]));
    check("rd_a4",    32'(rd_data_a4),   32'(m_regs[rd_addr_a]));
  endtask

  // One clock: drive inputs, let the edge happen, then compare on the falling edge.
  task automatic cycle(input logic e, input logic h, input logic wo,
                       input logic [2:0] wa, input logic [15:0] d);
    exec = e; halt_req = h; writeOrder = wo; write_add = wa; wb_data = d;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    cyc++;
    check_all();
    $display("[TB] cyc %0d exec=%0b halt=%0b wo=%0b wa=%0d d=%h -> phase=%b cnt=%0d",
             cyc, e, h, wo, wa, d, phase, instr_count);
  endtask

  task automatic rand_cycle();
    cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_phase", 32'(phase), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    reset_n = 1'b1; exec = 1'b0; halt_req = 1'b0; write_add = 3'd0;
    writeOrder = 1'b0; wb_data = 16'h0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    model_reset();

    // Reset state
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      check("rst_rd_a", 32'(rd_data_a), 32'h0);
      check("rst_rd_b", 32'(rd_data_b), 32'h0);
    end
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);

    // Write 0xBEEF to r5; writeOrder asserted in P1..P4 must not write
    cycle(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 3'd5, 16'(16'h1000 + i));
    check("pre_p5_phase", 32'(phase), 32'h10);
    rd_addr_a = 3'd5; #1;
    check("r5_untouched", 32'(rd_data_a), 32'h0);
    cycle(0, 0, 1, 3'd5, 16'hBEEF);
    rd_addr_a = 3'd5; rd_addr_b = 3'd5; #1;
    check("r5_beef_a", 32'(rd_data_a), 32'hBEEF);
    check("r5_beef_b", 32'(rd_data_b), 32'hBEEF);
    check("count_one", 32'(instr_count), 32'd1);

    // P5 without writeOrder: no write, count still increments
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 3'd5, 16'hDEAD);
    cycle(0, 0, 0, 3'd5, 16'h1234);
    rd_addr_a = 3'd5; #1;
    check("r5_kept", 32'(rd_data_a), 32'hBEEF);
    check("count_two", 32'(instr_count), 32'd2);

    // Halt with a write of 0x00FF to r0
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 3'd0, 16'h0);
    cycle(0, 1, 1, 3'd0, 16'h00FF);
    rd_addr_a = 3'd0; #1;
    check("halt_phase", 32'(phase), 32'd0);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_r0", 32'(rd_data_a), 32'h00FF);
    cycle(0, 0, 1, 3'd1, 16'h5555);
    cycle(0, 0, 1, 3'd1, 16'h5555);
    check("halt_count_hold", 32'(instr_count), 32'd3);
    cycle(1, 0, 0, 3'd0, 16'h0);
    check("resume_phase", 32'(phase), 32'h01);
    check("resume_halted", 32'(halted), 32'd0);

    // Asynchronous reset in P3
    cycle(0, 0, 0, 3'd0, 16'h0);
    cycle(0, 0, 0, 3'd0, 16'h0);
    check("in_p3", 32'(phase), 32'h04);
    #2;
    reset_n = 1'b0;
    model_reset();
    rd_addr_a = 3'd5;
    #1;
    check("async_phase", 32'(phase), 32'd0);
    check("async_r5", 32'(rd_data_a), 32'h0);
    check("async_count", 32'(instr_count), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // Counter wrap on the 4-bit instance: 17 instructions
    cycle(1, 0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 85; i++)
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 16'($urandom));
    check("wrap_count4", 32'(instr_count4), 32'd1);
    check("wrap_count16", 32'(instr_count), 32'd17);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
